x4xx_pps_sync_ctrl: RTL and testbench

// Control-clock sequencer for the PPS/LMK-sync datapath.
// - Captures a software PPS configuration on a start pulse.
// - Holds the config stable long enough for the downstream synchronizers.
// - Runs the pll_sync_trigger/pll_sync_done handshake with timeout.
// - Re-enables the radio-clock PPS output only after the LMK SYNC has completed.
// - Sits between the global register file and x4xx_pps_sync.
//

---
 rtl/x4xx_pps_sync_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_x4xx_pps_sync_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x4xx_pps_sync_ctrl.sv
// Control-clock sequencer for the PPS / LMK-sync datapath: captures a PPS config on start,
// runs the pll_sync_trigger/pll_sync_done handshake with timeout, then enables RC PPS.
module x4xx_pps_sync_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  cfg_pps_select,
  input  logic [7:0]  cfg_sync_delay,
  input  logic [7:0]  cfg_brc_delay,
  input  logic [25:0] cfg_prc_delay,
  input  logic [1:0]  cfg_rc_divider,
  input  logic        pll_sync_done,
  output logic [1:0]  pps_select,
  output logic [7:0]  pll_sync_delay,
  output logic [7:0]  pps_brc_delay,
  output logic [25:0] pps_prc_delay,
  output logic [1:0]  prc_rc_divider,
  output logic        pll_sync_trigger,
  output logic        pps_rc_enabled,
  output logic        busy,
  output logic        seq_done,
  output logic        timeout_err,
  output logic [2:0]  state_dbg
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLast  = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [26:0]        TimeoutLast = 27'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetup   = 3'd1,
    StTrigger = 3'd2,
    StRelease = 3'd3,
    StEnable  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [SettleW-1:0]   settle_q, settle_d;
  logic [26:0]          tmo_q, tmo_d;
  logic                 trig_q, trig_d;
  logic                 rc_en_q, rc_en_d;
  logic                 seq_done_q, seq_done_d;
  logic                 tmo_err_q, tmo_err_d;
  logic                 cfg_load;
  logic                 tmo_hit;

  assign tmo_hit = (tmo_q == TimeoutLast);

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    tmo_d      = tmo_q;
    trig_d     = trig_q;
    rc_en_d    = rc_en_q;
    seq_done_d = seq_done_q;
    tmo_err_d  = tmo_err_q;
    cfg_load   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          cfg_load   = 1'b1;
          rc_en_d    = 1'b0;
          seq_done_d = 1'b0;
          tmo_err_d  = 1'b0;
          settle_d   = '0;
          tmo_d      = '0;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (!pll_sync_done && settle_q == SettleLast) begin
          trig_d  = 1'b1;
          tmo_d   = '0;
          state_d = StTrigger;
        end else begin
          // A stale done stalls the settle count but the timeout keeps running.
          if (!pll_sync_done) settle_d = settle_q + SettleW'(1);
          if (tmo_hit) begin
            trig_d    = 1'b0;
            rc_en_d   = 1'b0;
            tmo_err_d = 1'b1;
            state_d   = StIdle;
          end else begin
            tmo_d = tmo_q + 27'd1;
          end
        end
      end
      StTrigger: begin
        if (pll_sync_done) begin
          trig_d  = 1'b0;
          tmo_d   = '0;
          state_d = StRelease;
        end else if (tmo_hit) begin
          trig_d    = 1'b0;
          rc_en_d   = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + 27'd1;
        end
      end
      StRelease: begin
        if (!pll_sync_done) begin
          settle_d = '0;
          state_d  = StEnable;
        end else if (tmo_hit) begin
          trig_d    = 1'b0;
          rc_en_d   = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + 27'd1;
        end
      end
      StEnable: begin
        if (settle_q == SettleLast) begin
          rc_en_d    = 1'b1;
          seq_done_d = 1'b1;
          state_d    = StIdle;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything else; sticky flags are left untouched.
    if (abort && state_q != StIdle) begin
      state_d    = StIdle;
      trig_d     = 1'b0;
      rc_en_d    = 1'b0;
      seq_done_d = seq_done_q;
      tmo_err_d  = tmo_err_q;
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_rst) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      tmo_q      <= '0;
      trig_q     <= 1'b0;
      rc_en_q    <= 1'b0;
      seq_done_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      trig_q     <= trig_d;
      rc_en_q    <= rc_en_d;
      seq_done_q <= seq_done_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_rst) begin
      pps_select     <= '0;
      pll_sync_delay <= '0;
      pps_brc_delay  <= '0;
      pps_prc_delay  <= '0;
      prc_rc_divider <= '0;
    end else if (cfg_load) begin
      pps_select     <= cfg_pps_select;
      pll_sync_delay <= cfg_sync_delay;
      pps_brc_delay  <= cfg_brc_delay;
      pps_prc_delay  <= cfg_prc_delay;
      prc_rc_divider <= cfg_rc_divider;
    end
  end

  assign pll_sync_trigger = trig_q;
  assign pps_rc_enabled   = rc_en_q;
  assign seq_done         = seq_done_q;
  assign timeout_err      = tmo_err_q;
  assign busy             = (state_q != StIdle);
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_x4xx_pps_sync_ctrl.sv
// Directed bench for x4xx_pps_sync_ctrl with SETTLE_CYCLES=4, TIMEOUT_CYCLES=100.
module tb_x4xx_pps_sync_ctrl;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_rst;
  logic        start;
  logic        abort;
  logic [1:0]  cfg_pps_select;
  logic [7:0]  cfg_sync_delay;
  logic [7:0]  cfg_brc_delay;
  logic [25:0] cfg_prc_delay;
  logic [1:0]  cfg_rc_divider;
  logic        pll_sync_done;
  logic [1:0]  pps_select;
  logic [7:0]  pll_sync_delay;
  logic [7:0]  pps_brc_delay;
  logic [25:0] pps_prc_delay;
  logic [1:0]  prc_rc_divider;
  logic        pll_sync_trigger;
  logic        pps_rc_enabled;
  logic        busy;
  logic        seq_done;
  logic        timeout_err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int passes = 0;

  logic [45:0] cfg_out;
  assign cfg_out = {pps_select, pll_sync_delay, pps_brc_delay, pps_prc_delay, prc_rc_divider};

  x4xx_pps_sync_ctrl #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .ctrl_clk        (ctrl_clk),
    .ctrl_rst        (ctrl_rst),
    .start           (start),
    .abort           (abort),
    .cfg_pps_select  (cfg_pps_select),
    .cfg_sync_delay  (cfg_sync_delay),
    .cfg_brc_delay   (cfg_brc_delay),
    .cfg_prc_delay   (cfg_prc_delay),
    .cfg_rc_divider  (cfg_rc_divider),
    .pll_sync_done   (pll_sync_done),
    .pps_select      (pps_select),
    .pll_sync_delay  (pll_sync_delay),
    .pps_brc_delay   (pps_brc_delay),
    .pps_prc_delay   (pps_prc_delay),
    .prc_rc_divider  (prc_rc_divider),
    .pll_sync_trigger(pll_sync_trigger),
    .pps_rc_enabled  (pps_rc_enabled),
    .busy            (busy),
    .seq_done        (seq_done),
    .timeout_err     (timeout_err),
    .state_dbg       (state_dbg)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge ctrl_clk);
      #1;
    end
  endtask

  task automatic set_cfg(input logic [45:0] c);
    {cfg_pps_select, cfg_sync_delay, cfg_brc_delay, cfg_prc_delay, cfg_rc_divider} = c;
  endtask

  // Pulse start for one cycle; returns in cycle N+1.
  task automatic start_seq(input logic [45:0] c);
    set_cfg(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From N+1: fast done handshake, returns in the completion cycle N+11.
  task automatic fast_finish();
    tick(4);
    pll_sync_done = 1'b1;
    tick();
    pll_sync_done = 1'b0;
    tick();
    tick(4);
  endtask

  task automatic test_reset();
    ctrl_rst = 1'b1;
    tick(2);
    checks++;
    if (cfg_out !== 46'd0) $display("FAIL reset_cfg: got %h want 0", cfg_out);
    else passes++;
    checks++;
    if ({pll_sync_trigger, pps_rc_enabled, busy, seq_done, timeout_err} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {pll_sync_trigger, pps_rc_enabled, busy, seq_done, timeout_err});
    else passes++;
    checks++;
    if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_dbg);
    else passes++;
    ctrl_rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    logic [45:0] c = {2'd1, 8'd5, 8'd20, 26'd1000, 2'd2};
    start_seq(c);
    checks++;
    if (cfg_out !== c) $display("FAIL nom_cfg_capture: got %h want %h", cfg_out, c);
    else passes++;
    checks++;
    if (state_dbg !== 3'd1 || busy !== 1'b1)
      $display("FAIL nom_setup: got state %0d busy %b want 1 1", state_dbg, busy);
    else passes++;
    tick(3);
    checks++;
    if (pll_sync_trigger !== 1'b0) $display("FAIL nom_trig_early: got %b want 0", pll_sync_trigger);
    else passes++;
    tick();
    checks++;
    if (pll_sync_trigger !== 1'b1 || state_dbg !== 3'd2)
      $display("FAIL nom_trig_rise: got trig %b state %0d want 1 2", pll_sync_trigger, state_dbg);
    else passes++;
    tick(10);
    pll_sync_done = 1'b1;
    tick();
    checks++;
    if (pll_sync_trigger !== 1'b0 || state_dbg !== 3'd3)
      $display("FAIL nom_release: got trig %b state %0d want 0 3", pll_sync_trigger, state_dbg);
    else passes++;
    tick(3);
    pll_sync_done = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 3'd4) $display("FAIL nom_enable: got state %0d want 4", state_dbg);
    else passes++;
    tick(3);
    checks++;
    if (busy !== 1'b1 || pps_rc_enabled !== 1'b0)
      $display("FAIL nom_pre_done: got busy %b rc_en %b want 1 0", busy, pps_rc_enabled);
    else passes++;
    // start coinciding with ENABLE completion must be dropped
    set_cfg({2'd3, 8'd9, 8'd9, 26'd9, 2'd3});
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({pps_rc_enabled, seq_done, busy, timeout_err} !== 4'b1100)
      $display("FAIL nom_done: got rc_en/seq_done/busy/tmo %b want 1100",
               {pps_rc_enabled, seq_done, busy, timeout_err});
    else passes++;
    tick();
    checks++;
    if (state_dbg !== 3'd0 || cfg_out !== c)
      $display("FAIL nom_late_start: got state %0d cfg %h want 0 %h", state_dbg, cfg_out, c);
    else passes++;
  endtask

  task automatic test_timeout_trigger();
    start_seq({2'd2, 8'd1, 8'd2, 26'd3, 2'd1});
    checks++;
    if (seq_done !== 1'b0 || pps_rc_enabled !== 1'b0)
      $display("FAIL tmo_clear: got seq_done %b rc_en %b want 0 0", seq_done, pps_rc_enabled);
    else passes++;
    tick(4);
    tick(99);
    checks++;
    if (pll_sync_trigger !== 1'b1 || timeout_err !== 1'b0)
      $display("FAIL tmo_trig_pre: got trig %b tmo %b want 1 0", pll_sync_trigger, timeout_err);
    else passes++;
    tick();
    checks++;
    if ({pll_sync_trigger, timeout_err, state_dbg, pps_rc_enabled} !== 6'b0_1_000_0)
      $display("FAIL tmo_trig: got trig/tmo/state/rc_en %b want 010000",
               {pll_sync_trigger, timeout_err, state_dbg, pps_rc_enabled});
    else passes++;
  endtask

  task automatic test_stuck_done();
    logic        saw_trig = 1'b0;
    logic [45:0] c        = {2'd3, 8'd7, 8'd8, 26'd12345, 2'd0};
    pll_sync_done = 1'b1;
    start_seq(c);
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL stuck_clear: got tmo %b want 0", timeout_err);
    else passes++;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (pll_sync_trigger) saw_trig = 1'b1;
    end
    checks++;
    if (state_dbg !== 3'd1 || timeout_err !== 1'b0 || saw_trig !== 1'b0)
      $display("FAIL stuck_setup: got state %0d tmo %b trig_seen %b want 1 0 0",
               state_dbg, timeout_err, saw_trig);
    else passes++;
    tick();
    checks++;
    if (timeout_err !== 1'b1 || state_dbg !== 3'd0 || cfg_out !== c)
      $display("FAIL stuck_tmo: got tmo %b state %0d cfg %h want 1 0 %h",
               timeout_err, state_dbg, cfg_out, c);
    else passes++;
    pll_sync_done = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    start_seq({2'd1, 8'd2, 8'd3, 26'd4, 2'd1});
    tick(4);
    tick(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({pll_sync_trigger, state_dbg, seq_done, timeout_err, busy} !== 7'b0)
      $display("FAIL abort: got trig/state/seq/tmo/busy %b want 0000000",
               {pll_sync_trigger, state_dbg, seq_done, timeout_err, busy});
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [45:0] c = {2'd2, 8'd33, 8'd44, 26'd555, 2'd3};
    start_seq(c);
    tick();
    set_cfg({2'd0, 8'd1, 8'd1, 26'd1, 2'd0});
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (cfg_out !== c || state_dbg !== 3'd1)
      $display("FAIL busy_start: got cfg %h state %0d want %h 1", cfg_out, state_dbg, c);
    else passes++;
    // finish the sequence; start pulse did not shift the trigger point (N+5)
    tick(2);
    pll_sync_done = 1'b1;
    tick();
    pll_sync_done = 1'b0;
    tick();
    tick(4);
    checks++;
    if (pps_rc_enabled !== 1'b1 || seq_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_done: got rc_en %b seq %b busy %b want 1 1 0",
               pps_rc_enabled, seq_done, busy);
    else passes++;
    set_cfg({2'd1, 8'd1, 8'd1, 26'd1, 2'd1});
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (cfg_out !== c || state_dbg !== 3'd0 || pps_rc_enabled !== 1'b1 || seq_done !== 1'b1)
      $display("FAIL start_abort_idle: got cfg %h state %0d rc_en %b seq %b want %h 0 1 1",
               cfg_out, state_dbg, pps_rc_enabled, seq_done, c);
    else passes++;
  endtask

  task automatic test_reset_release();
    logic [45:0] c = {2'd3, 8'd100, 8'd200, 26'd777, 2'd1};
    start_seq({2'd1, 8'd1, 8'd2, 26'd3, 2'd2});
    tick(4);
    pll_sync_done = 1'b1;
    tick();
    checks++;
    if (state_dbg !== 3'd3) $display("FAIL rst_in_release: got state %0d want 3", state_dbg);
    else passes++;
    ctrl_rst = 1'b1;
    tick();
    checks++;
    if ({cfg_out, pll_sync_trigger, pps_rc_enabled, busy, seq_done, timeout_err, state_dbg}
        !== 54'd0)
      $display("FAIL rst_mid_seq: got cfg %h trig %b busy %b state %0d want all 0",
               cfg_out, pll_sync_trigger, busy, state_dbg);
    else passes++;
    ctrl_rst = 1'b0;
    pll_sync_done = 1'b0;
    tick();
    start_seq(c);
    fast_finish();
    checks++;
    if (pps_rc_enabled !== 1'b1 || seq_done !== 1'b1 || busy !== 1'b0 || cfg_out !== c)
      $display("FAIL rst_then_run: got rc_en %b seq %b busy %b cfg %h want 1 1 0 %h",
               pps_rc_enabled, seq_done, busy, cfg_out, c);
    else passes++;
  endtask

  initial begin
    ctrl_rst      = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    pll_sync_done = 1'b0;
    set_cfg(46'd0);
    test_reset();
    test_nominal();
    test_timeout_trigger();
    test_stuck_done();
    test_abort();
    test_back_to_back();
    test_reset_release();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
